sm_reg_dump: RTL and testbench
==============================

// Module: sm_reg_dump
// PURPOSE
//  Debug dump engine on the sm_cpu debug ports. On a start pulse it walks
//  regAddr 0..31 (0 returns the PC), captures each regData word, and sends it
//  over a UART TX line as 8 uppercase ASCII hex digits plus CR LF.
//  It lets the board show CPU state without a JTAG probe.
// PARAMETERS
//  BAUD_DIV  434  clk cycles per UART bit (50 MHz / 115200); legal range >= 2
// PORTS
//  clk          in   1   system clock; all logic on rising edge
//  rst_n        in   1   reset, synchronous, active-low
//  start        in   1   dump request, sampled only in IDLE
//  busy         out  1   high while a dump is in progress
//  done         out  1   one-cycle pulse when a dump completes
//  regAddr      out  5   debug register address to the CPU
//  regData      in   32  debug register data from the CPU (combinational)
//  memAddrB     out  4   RAM port-B address (driven only with the RAM option)
//  memDataOutB  in   32  RAM port-B data (registered read, 1-cycle latency)
//  tx           out  1   UART serial output: 8N1, LSB first, idle high
// BEHAVIOUR
//  Reset values: tx=1, busy=0, done=0, regAddr=0, memAddrB=0; FSM in IDLE; counters 0.
//  Reset mid-dump aborts at the next edge: tx=1 immediately, no partial frame is completed.
//  FSM states and transitions:
//   IDLE    start=1 -> SETUP0, word index=0, busy=1 from the next cycle
//   SETUP0  drive address = index -> SETUP1
//   SETUP1  address held; at the end of this cycle, capture the source word into a 32-bit snapshot -> BYTE
//   BYTE    load the next character and reset the bit counter -> TXBITS
//   TXBITS  send the start bit (0), d0..d7, then the stop bit (1); each bit lasts BAUD_DIV cycles
//           after the stop bit: if characters remain -> TXBITS with the next character, with no idle gap
//           after character 10: if more words remain -> SETUP0 with index+1, else -> IDLE
//   On entering IDLE from TXBITS: done=1 for that cycle, and busy falls in the same cycle.
//  Character order per word: nibbles [31:28] down to [3:0], then 0x0D, then 0x0A.
//  Nibble encoding: 0..9 -> 0x30..0x39; A..F -> 0x41..0x46.
//  tx stays 1 during SETUP0/SETUP1 (2 idle cycles between words).
//  The snapshot is taken once per word; CPU activity during transmission does not alter the bytes sent.
//  start while busy=1 is ignored; it is not queued.
//  start held high continuously re-triggers a new dump in the cycle after done.
//  Default dump = 32 words; busy stays high for exactly 32*(2+100*BAUD_DIV) cycles.
//  Word counter is 6 bits; no wrap-around occurs within a dump.
//  regAddr holds its last value (31) after the dump and returns to 0 only on reset.
// CONFIGURATION
//  SM_REG_DUMP_RAM_EN defined:
//   after register 31, words 32..47 are dumped from the RAM, with memAddrB = index-32 (0..15)
//   memDataOutB is captured at the end of SETUP1, which covers the 1-cycle read latency
//   total 48 words; busy length = 48*(2+100*BAUD_DIV) cycles
//  SM_REG_DUMP_RAM_EN undefined:
//   memAddrB is tied to 0, memDataOutB is unused, and the dump is 32 words
// TESTING  (BAUD_DIV=4 in all benches)
//  1 Reset: rst_n=0 for 3 cycles, with start=1 -> tx=1, busy=0, done=0, regAddr=0; no frame is sent.
//  2 Data: PC=0x00000010, r1=0x1234ABCD, start pulse ->
//    first 10 bytes are "00000010\r\n"
//    next 10 bytes are 31 32 33 34 41 42 43 44 0D 0A
//    every start bit and stop bit lasts exactly 4 cycles
//  3 Timing: one start pulse -> busy high for exactly 12864 cycles
//    done high for 1 cycle, at the cycle busy falls; 320 frames decoded in total
//  4 Busy start: start pulse at cycle 500 of a dump -> no second dump; byte count stays 320.
//  5 Reset mid-dump: rst_n=0 during a data bit of byte 57 ->
//    tx=1, busy=0 at the next edge; a new start gives a full, correct 320-byte dump
//  6 RAM option (SM_REG_DUMP_RAM_EN): RAM[15]=0xDEADBEEF ->
//    last word sent is "DEADBEEF\r\n"; 480 bytes in total; busy lasts 19296 cycles

Source files
------------

// File: rtl/sm_reg_dump.sv
// sm_reg_dump: debug dump engine for the sm_cpu debug ports.
// A start pulse walks regAddr 0..31 (address 0 returns the PC), snapshots each
// regData word and sends it on a UART TX line as 8 uppercase ASCII hex digits
// followed by CR LF (8N1, LSB first, idle high).
//
// Optional build macro: SM_REG_DUMP_RAM_EN
//   When defined, 16 extra words (indices 32..47) follow the registers.
//   They are read from RAM port B with memAddrB = index-32.
//   When undefined, memAddrB is tied to 0, memDataOutB is ignored and the
//   dump is 32 words.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        dump request, sampled only when idle
//   busy         high while a dump is in progress
//   done         one-cycle pulse when a dump completes
//   regAddr      debug register address to the CPU
//   regData      debug register data from the CPU (combinational)
//   memAddrB     RAM port-B address (RAM option only)
//   memDataOutB  RAM port-B data (1-cycle registered read)
//   tx           UART serial output
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; tx high
// S_SETUP0 | address for the current word is on regAddr/memAddrB
// S_SETUP1 | address held; source word is snapshotted at the end
// S_BYTE   | first cycle of the first start bit; first character loaded
// S_TXBITS | shifting frames out, characters back to back
module sm_reg_dump #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [3:0]  memAddrB,
  input  logic [31:0] memDataOutB,
  output logic        tx
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BIT_RELOAD   = BW'(BAUD_DIV - 1);
  // The S_BYTE cycle already drives the start bit, so the first start bit
  // of each word spends one cycle less in S_TXBITS.
  localparam logic [BW-1:0] START_RELOAD = BW'(BAUD_DIV - 2);
`ifdef SM_REG_DUMP_RAM_EN
  localparam logic [5:0] LAST_WORD = 6'd47;
`else
  localparam logic [5:0] LAST_WORD = 6'd31;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP0, S_SETUP1, S_BYTE, S_TXBITS
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   snap_q, snap_d;
  logic [3:0]    char_q, char_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          done_q, done_d;
  logic [5:0]    idx_nx;
`ifdef SM_REG_DUMP_RAM_EN
  logic [3:0]    mem_addr_q, mem_addr_d;
`endif

  // Characters 0..7 are the nibbles MSB first, 8 is CR, 9 is LF.
  function automatic logic [7:0] char_of(input logic [31:0] w, input logic [3:0] ci);
    logic [31:0] sh;
    logic [3:0]  nib;
    sh  = w << {ci[2:0], 2'b00};
    nib = sh[31:28];
    if (ci == 4'd8)       char_of = 8'h0D;
    else if (ci == 4'd9)  char_of = 8'h0A;
    else if (nib < 4'd10) char_of = {4'h3, nib};
    else                  char_of = 8'h37 + {4'h0, nib};
  endfunction

  assign idx_nx = idx_q + 6'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    snap_d  = snap_q;
    char_d  = char_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    done_d  = 1'b0;
`ifdef SM_REG_DUMP_RAM_EN
    mem_addr_d = mem_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP0;
          idx_d   = 6'd0;
          addr_d  = 5'd0;
`ifdef SM_REG_DUMP_RAM_EN
          mem_addr_d = 4'd0;
`endif
        end
      end
      S_SETUP0: state_d = S_SETUP1;
      S_SETUP1: begin
`ifdef SM_REG_DUMP_RAM_EN
        snap_d = idx_q[5] ? memDataOutB : regData;
`else
        snap_d = regData;
`endif
        char_d  = 4'd0;
        state_d = S_BYTE;
      end
      S_BYTE: begin
        frame_d = {1'b1, char_of(snap_q, char_q), 1'b0};
        bit_d   = 4'd0;
        baud_d  = START_RELOAD;
        state_d = S_TXBITS;
      end
      S_TXBITS: begin
        if (baud_q != '0) begin
          baud_d = baud_q - BW'(1);
        end else if (bit_q != 4'd9) begin
          frame_d = {1'b1, frame_q[9:1]};
          bit_d   = bit_q + 4'd1;
          baud_d  = BIT_RELOAD;
        end else if (char_q != 4'd9) begin
          char_d  = char_q + 4'd1;
          frame_d = {1'b1, char_of(snap_q, char_q + 4'd1), 1'b0};
          bit_d   = 4'd0;
          baud_d  = BIT_RELOAD;
        end else if (idx_q == LAST_WORD) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_nx;
          state_d = S_SETUP0;
          // regAddr stays at 31 while RAM words are being dumped.
          if (!idx_nx[5]) addr_d = idx_nx[4:0];
`ifdef SM_REG_DUMP_RAM_EN
          else            mem_addr_d = idx_nx[3:0];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      snap_q  <= '0;
      char_q  <= '0;
      frame_q <= '1;
      bit_q   <= '0;
      baud_q  <= '0;
      done_q  <= 1'b0;
`ifdef SM_REG_DUMP_RAM_EN
      mem_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      snap_q  <= snap_d;
      char_q  <= char_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      done_q  <= done_d;
`ifdef SM_REG_DUMP_RAM_EN
      mem_addr_q <= mem_addr_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign regAddr = addr_q;
  assign tx      = (state_q == S_BYTE)   ? 1'b0 :
                   (state_q == S_TXBITS) ? frame_q[0] : 1'b1;

`ifdef SM_REG_DUMP_RAM_EN
  assign memAddrB = mem_addr_q;
`else
  logic unused_mem_data;
  assign memAddrB        = 4'd0;
  assign unused_mem_data = ^memDataOutB;
`endif

endmodule

// File: tb/tb_sm_reg_dump.sv
module tb_sm_reg_dump;
  localparam int BAUD = 4;
`ifdef SM_REG_DUMP_RAM_EN
  localparam int NW = 48;
`else
  localparam int NW = 32;
`endif
  localparam int DUMP_CYC = NW * (2 + 100 * BAUD);

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, tx;
  logic [4:0]  regAddr;
  logic [31:0] regData, memDataOutB, noise;
  logic [3:0]  memAddrB;

  logic [31:0] regs [32];
  logic [31:0] ram [16];
  logic [31:0] ref_words [NW];
  byte unsigned rx_q[$];
  byte unsigned exp_q[$];
  byte unsigned spec20 [20] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h0D, 8'h0A,
                                8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
  string hexd = "0123456789ABCDEF";

  int errors = 0, checks = 0;
  int busy_cycles = 0, done_cnt = 0, done_bad = 0, shape_err = 0;
  int last_rb;
  bit scramble_en = 1'b0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  // Noise only appears while a word is being shifted out, after its snapshot.
  assign regData = regs[regAddr] ^ noise;
  always @(posedge clk) memDataOutB <= ram[memAddrB];
  always @(negedge clk)
    noise = (scramble_en && busy === 1'b1 && tx === 1'b0) ? $urandom : 32'h0;

  sm_reg_dump #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .regAddr(regAddr), .regData(regData), .memAddrB(memAddrB),
    .memDataOutB(memDataOutB), .tx(tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0 || busy_prev !== 1'b1) done_bad++;
    end
    busy_prev = busy;
  end

  // UART receiver: every bit must hold its level for all BAUD cycles.
  initial begin : uart_rx
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin : frame
        logic [9:0] bits;
        logic v;
        bit stable, aborted;
        bits = '0; v = 1'b0; stable = 1'b1; aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < BAUD; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            if (c == 0) v = tx;
            else if (tx !== v) stable = 1'b0;
          end
          bits[b] = v;
        end
        if (!aborted) begin
          rx_q.push_back(bits[8:1]);
          if (!stable || bits[0] !== 1'b0 || bits[9] !== 1'b1) shape_err++;
        end
      end
    end
  end

  task automatic build_exp();
    exp_q.delete();
    for (int w = 0; w < NW; w++) begin
      ref_words[w] = (w < 32) ? regs[w] : ram[w - 32];
      for (int n = 7; n >= 0; n--) exp_q.push_back(hexd[ref_words[w][4*n +: 4]]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic run_dump(input string tag, input bit inject);
    int rb, bb, db, dbad, sb, t;
    bit seen;
    build_exp();
    rb = rx_q.size(); bb = busy_cycles; db = done_cnt; dbad = done_bad; sb = shape_err;
    last_rb = rb;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0; t = 0;
    while (!seen && t < DUMP_CYC + 2000) begin
      @(negedge clk); t++;
      start = inject && (t == 500);
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    repeat (30) @(negedge clk);
    chk({tag, ".busy_len"}, busy_cycles - bb, DUMP_CYC);
    chk({tag, ".done_cnt"}, done_cnt - db, 1);
    chk({tag, ".done_align"}, done_bad - dbad, 0);
    chk({tag, ".bit_shape"}, shape_err - sb, 0);
    chk({tag, ".nbytes"}, rx_q.size() - rb, 10 * NW);
    chk({tag, ".idle_after"}, 32'(busy), 32'd0);
    chk({tag, ".regaddr_hold"}, 32'(regAddr), 32'd31);
    for (int i = 0; i < 10 * NW; i++)
      if (rb + i < rx_q.size())
        chk($sformatf("%s.byte%0d", tag, i), 32'(rx_q[rb + i]), 32'(exp_q[i]));
  endtask

  initial begin : main
    int t, rb;
    bit seen;
    for (int i = 0; i < 16; i++) ram[i] = $urandom;
    ram[15] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;

    // Reset with start held high
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.tx", 32'(tx), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.regaddr", 32'(regAddr), 32'd0);
    chk("rst.memaddr", 32'(memAddrB), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst.no_frame", rx_q.size(), 0);
    chk("rst.still_idle", 32'(busy), 32'd0);

    // Known data: PC and r1
    regs[0] = 32'h0000_0010;
    regs[1] = 32'h1234_ABCD;
    run_dump("basic", 1'b0);
    for (int i = 0; i < 20; i++)
      if (last_rb + i < rx_q.size())
        chk($sformatf("basic.spec%0d", i), 32'(rx_q[last_rb + i]), 32'(spec20[i]));
`ifdef SM_REG_DUMP_RAM_EN
    chk("ram.last_word_D", 32'(rx_q[rx_q.size() - 10]), 32'h44);
`endif

    // Random data, CPU noise during transmission, start pulse while busy
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    scramble_en = 1'b1;
    run_dump("busy_start", 1'b1);
    scramble_en = 1'b0;

    // Reset during a data bit of byte 57
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    rb = rx_q.size(); t = 0;
    while (rx_q.size() - rb < 56 && t < 5000) begin @(negedge clk); t++; end
    chk("midrst.reach56", rx_q.size() - rb, 56);
    t = 0;
    while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.tx", 32'(tx), 32'd1);
    chk("midrst.busy", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    chk("midrst.no_partial", rx_q.size() - rb, 56);
    chk("midrst.regaddr", 32'(regAddr), 32'd0);
    rst_n = 1'b1;
    run_dump("post_rst", 1'b0);

    // start held high re-triggers right after done
    @(negedge clk); start = 1'b1;
    seen = 1'b0; t = 0;
    while (!seen && t < DUMP_CYC + 2000) begin
      @(negedge clk); t++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("retrig.done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("retrig.busy", 32'(busy), 32'd1);
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
